// File: rtl/cr_tlvp_gen_if.sv
// Request, payload and output-FIFO signals of the TLV frame generator.
// The slave modport is the generator; master is whoever feeds and drains it.
interface cr_tlvp_gen_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_type;
  logic [15:0] req_nwords;
  logic [39:0] req_ext;
  logic        pl_valid;
  logic        pl_ready;
  logic [63:0] pl_data;
  logic [7:0]  pl_strb;
  logic        ob_rd;
  logic        ob_empty;
  logic        ob_aempty;
  logic [63:0] ob_tdata;
  logic [7:0]  ob_tstrb;
  logic [7:0]  ob_tuser;
  logic        ob_tlast;
  logic        gen_busy;
  logic        gen_err;
  logic [31:0] tlv_cnt;

  modport master (
    output req_valid, req_type, req_nwords, req_ext,
    output pl_valid, pl_data, pl_strb, ob_rd,
    input  req_ready, pl_ready, ob_empty, ob_aempty,
    input  ob_tdata, ob_tstrb, ob_tuser, ob_tlast,
    input  gen_busy, gen_err, tlv_cnt
  );

  modport slave (
    input  req_valid, req_type, req_nwords, req_ext,
    input  pl_valid, pl_data, pl_strb, ob_rd,
    output req_ready, pl_ready, ob_empty, ob_aempty,
    output ob_tdata, ob_tstrb, ob_tuser, ob_tlast,
    output gen_busy, gen_err, tlv_cnt
  );
endinterface

// File: rtl/cr_tlvp_gen.sv
// TLV frame generator: header word plus payload words into a show-ahead output FIFO.
//   state | meaning
//   IDLE  | waiting for a request (req_ready=1)
//   HDR   | writing the header word once the FIFO has room
//   PAY   | forwarding payload words until the remaining count hits the last word
module cr_tlvp_gen #(
  parameter int N_OB_ENTRIES    = 16,
  parameter int N_OB_AEMPTY_VAL = 1,
  parameter int MAX_PL_WORDS    = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  cr_tlvp_gen_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        sot;
    logic        eot;
    logic        last;
  } entry_t;

  localparam int PTR_W = $clog2(N_OB_ENTRIES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH  = CNT_W'(N_OB_ENTRIES);
  localparam logic [CNT_W-1:0] AEMPTY = CNT_W'(N_OB_AEMPTY_VAL);
  localparam logic [15:0]      MAX_PL = 16'(MAX_PL_WORDS);

  state_t             state_q, state_d;
  logic [7:0]         type_q;
  logic [15:0]        nwords_q;
  logic [39:0]        ext_q;
  logic [15:0]        rem_q;
  logic               req_ready_q;
  logic               pl_ready_q;
  logic               err_q;
  logic [31:0]        tlv_cnt_q;
  entry_t             mem_q [N_OB_ENTRIES];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               empty_q, aempty_q;

  logic               full, hdr_wr, pay_wr, wr_en, pay_last, pop, req_acc;
  entry_t             wr_entry, head;

  // Full is judged on the current count, so a same-cycle pop never frees a slot early.
  always_comb begin
    full     = (cnt_q == DEPTH);
    hdr_wr   = (state_q == HDR) && !full;
    pay_wr   = (state_q == PAY) && bus.pl_valid && pl_ready_q;
    wr_en    = hdr_wr || pay_wr;
    pay_last = (rem_q == 16'd1);
    pop      = bus.ob_rd && !empty_q;
    req_acc  = (state_q == IDLE) && bus.req_valid && req_ready_q;

    wr_entry = '0;
    if (hdr_wr) begin
      wr_entry.data = {ext_q, nwords_q + 16'd1, type_q};
      wr_entry.strb = 8'hFF;
      wr_entry.sot  = 1'b1;
      wr_entry.eot  = (nwords_q == 16'd0);
      wr_entry.last = (nwords_q == 16'd0);
    end else begin
      wr_entry.data = bus.pl_data;
      wr_entry.strb = pay_last ? bus.pl_strb : 8'hFF;
      wr_entry.eot  = pay_last;
      wr_entry.last = pay_last;
    end

    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - CNT_W'(1);

    state_d = state_q;
    case (state_q)
      IDLE:    if (req_acc && (bus.req_nwords <= MAX_PL)) state_d = HDR;
      HDR:     if (hdr_wr) state_d = (nwords_q == 16'd0) ? IDLE : PAY;
      PAY:     if (pay_wr && pay_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      type_q      <= '0;
      nwords_q    <= '0;
      ext_q       <= '0;
      rem_q       <= '0;
      req_ready_q <= 1'b1;
      pl_ready_q  <= 1'b0;
      err_q       <= 1'b0;
      tlv_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == IDLE);
      pl_ready_q  <= (state_d == PAY) && (cnt_d != DEPTH);
      if (req_acc) begin
        if (bus.req_nwords > MAX_PL) begin
          err_q <= 1'b1;
        end else begin
          type_q   <= bus.req_type;
          nwords_q <= bus.req_nwords;
          ext_q    <= bus.req_ext;
        end
      end
      if (hdr_wr)      rem_q <= nwords_q;
      else if (pay_wr) rem_q <= rem_q - 16'd1;
      if ((hdr_wr && nwords_q == 16'd0) || (pay_wr && pay_last))
        tlv_cnt_q <= tlv_cnt_q + 32'd1;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q    <= cnt_d;
      empty_q  <= (cnt_d == '0);
      aempty_q <= (cnt_d <= AEMPTY);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    head          = mem_q[rd_ptr_q];
    bus.ob_tdata  = empty_q ? 64'd0 : head.data;
    bus.ob_tstrb  = empty_q ? 8'd0  : head.strb;
    bus.ob_tuser  = empty_q ? 8'd0  : {6'd0, head.eot, head.sot};
    bus.ob_tlast  = empty_q ? 1'b0  : head.last;
  end

  assign bus.req_ready = req_ready_q;
  assign bus.pl_ready  = pl_ready_q;
  assign bus.ob_empty  = empty_q;
  assign bus.ob_aempty = aempty_q;
  assign bus.gen_busy  = (state_q != IDLE);
  assign bus.gen_err   = err_q;
  assign bus.tlv_cnt   = tlv_cnt_q;
endmodule

// File: tb/tb_cr_tlvp_gen.sv
// Randomized bench for cr_tlvp_gen: a word-level frame model feeds a scoreboard
// that is checked on every FIFO pop; directed phases cover backpressure, oversize and reset.
module tb_cr_tlvp_gen;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  user;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  cr_tlvp_gen_if bus ();

  cr_tlvp_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rd_mode = 0;
  int   gap_max = 0;
  int   pl_acc  = 0;
  logic [31:0] exp_tlv = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Consumer: decides ob_rd for the coming edge and checks the head word it will pop.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      case (rd_mode)
        0:       bus.ob_rd = 1'b0;
        1:       bus.ob_rd = 1'($urandom_range(0, 1));
        default: bus.ob_rd = 1'b1;
      endcase
      if (bus.ob_rd && !bus.ob_empty && rst_n) begin
        chk("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tdata", bus.ob_tdata, e.data);
          chk("tstrb", 64'(bus.ob_tstrb), 64'(e.strb));
          chk("tuser", 64'(bus.ob_tuser), 64'(e.user));
          chk("tlast", 64'(bus.ob_tlast), 64'(e.last));
        end
      end
    end
  end

  task automatic send_req(input logic [7:0] ty, input logic [15:0] nw, input logic [39:0] ex);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_type = ty; bus.req_nwords = nw; bus.req_ext = ex;
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.req_ready) chk("req_timeout", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic send_pl(input logic [63:0] d, input logic [7:0] s);
    int n = 0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    bus.pl_valid = 1'b1; bus.pl_data = d; bus.pl_strb = s;
    while (!bus.pl_ready && n < 500) begin @(negedge clk); n++; end
    if (!bus.pl_ready) chk("pl_timeout", 64'(bus.pl_ready), 64'd1);
    @(negedge clk);
    bus.pl_valid = 1'b0;
    pl_acc++;
  endtask

  // Model: a legal TLV is one header {ext,len=n+1,type} then n payload words.
  task automatic send_tlv(input logic [7:0] ty, input logic [15:0] nw,
                          input logic [39:0] ex, input logic [7:0] last_strb);
    exp_t e;
    logic [63:0] d;
    logic [7:0]  s;
    if (nw > 16'd256) begin
      send_req(ty, nw, ex);
      return;
    end
    e.data = {ex, nw + 16'd1, ty};
    e.strb = 8'hFF;
    e.user = (nw == 0) ? 8'h03 : 8'h01;
    e.last = (nw == 0);
    exp_q.push_back(e);
    exp_tlv++;
    send_req(ty, nw, ex);
    for (int i = 0; i < int'(nw); i++) begin
      d = {$urandom, $urandom};
      s = 8'($urandom);
      e.data = d;
      e.strb = (i == int'(nw) - 1) ? last_strb : 8'hFF;
      e.user = (i == int'(nw) - 1) ? 8'h02 : 8'h00;
      e.last = (i == int'(nw) - 1);
      exp_q.push_back(e);
      send_pl(d, (i == int'(nw) - 1) ? last_strb : s);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rd_mode = 2;
    while ((exp_q.size() != 0 || !bus.ob_empty) && n < 3000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) chk({tag, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_tlv_cnt"}, 64'(bus.tlv_cnt), 64'(exp_tlv));
    chk({tag, "_empty"}, 64'(bus.ob_empty), 64'd1);
    chk({tag, "_aempty"}, 64'(bus.ob_aempty), 64'd1);
    chk({tag, "_busy"}, 64'(bus.gen_busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.req_valid = 0; bus.req_type = 0; bus.req_nwords = 0; bus.req_ext = 0;
    bus.pl_valid = 0; bus.pl_data = 0; bus.pl_strb = 0; bus.ob_rd = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_pl_ready", 64'(bus.pl_ready), 64'd0);
    chk("rst_empty", 64'(bus.ob_empty), 64'd1);
    chk("rst_aempty", 64'(bus.ob_aempty), 64'd1);
    chk("rst_tdata", bus.ob_tdata, 64'd0);
    chk("rst_tuser", 64'({bus.ob_tstrb, bus.ob_tuser, bus.ob_tlast}), 64'd0);
    chk("rst_busy", 64'(bus.gen_busy), 64'd0);
    chk("rst_err", 64'(bus.gen_err), 64'd0);
    chk("rst_tlv_cnt", 64'(bus.tlv_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Header-only TLV, held in the FIFO so the head can be inspected directly.
    send_tlv(8'h05, 16'd0, 40'd0, 8'h00);
    repeat (3) @(negedge clk);
    chk("t1_tdata", bus.ob_tdata, 64'h0000_0000_0000_0105);
    chk("t1_tuser", 64'(bus.ob_tuser), 64'h03);
    chk("t1_tlast", 64'(bus.ob_tlast), 64'd1);
    chk("t1_tstrb", 64'(bus.ob_tstrb), 64'hFF);
    chk("t1_aempty", 64'(bus.ob_aempty), 64'd1);
    chk("t1_tlv_cnt", 64'(bus.tlv_cnt), 64'd1);
    drain("t1");

    rd_mode = 1;
    send_tlv(8'h01, 16'd3, 40'h12_3456_789A, 8'h0F);
    drain("t2");

    // Two words resident -> above the almost-empty threshold.
    rd_mode = 0;
    send_tlv(8'h22, 16'd1, 40'hAA, 8'h01);
    repeat (3) @(negedge clk);
    chk("aempty_2w", 64'(bus.ob_aempty), 64'd0);
    chk("empty_2w", 64'(bus.ob_empty), 64'd0);
    drain("t2b");

    // Backpressure: 20-word payload into a 16-entry FIFO with no reads.
    rd_mode = 0;
    gap_max = 0;
    base = pl_acc;
    fork
      send_tlv(8'h33, 16'd20, 40'hBEEF, 8'h3C);
      begin
        repeat (40) @(negedge clk);
        chk("bp_words", 64'(pl_acc - base), 64'd15);
        chk("bp_pl_ready", 64'(bus.pl_ready), 64'd0);
        chk("bp_aempty", 64'(bus.ob_aempty), 64'd0);
        chk("bp_busy", 64'(bus.gen_busy), 64'd1);
        rd_mode = 2;
      end
    join
    drain("t3");

    // Oversize request is dropped and flagged; the next one goes through.
    rd_mode = 0;
    send_tlv(8'h44, 16'd257, 40'd7, 8'h00);
    repeat (4) @(negedge clk);
    chk("ovr_err", 64'(bus.gen_err), 64'd1);
    chk("ovr_empty", 64'(bus.ob_empty), 64'd1);
    chk("ovr_req_ready", 64'(bus.req_ready), 64'd1);
    chk("ovr_busy", 64'(bus.gen_busy), 64'd0);
    send_tlv(8'h45, 16'd2, 40'd9, 8'h80);
    drain("t4");
    chk("err_sticky", 64'(bus.gen_err), 64'd1);

    // Largest legal payload.
    rd_mode = 2;
    send_tlv(8'h46, 16'd256, 40'hF_0000_0001, 8'hFF);
    drain("t4max");

    // Reset in the middle of a payload.
    rd_mode = 0;
    send_tlv(8'h55, 16'd0, 40'd1, 8'h00);
    send_req(8'h56, 16'd5, 40'd2);
    send_pl(64'h1111, 8'hFF);
    send_pl(64'h2222, 8'hFF);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst5_empty", 64'(bus.ob_empty), 64'd1);
    chk("rst5_busy", 64'(bus.gen_busy), 64'd0);
    chk("rst5_tlv_cnt", 64'(bus.tlv_cnt), 64'd0);
    chk("rst5_err", 64'(bus.gen_err), 64'd0);
    chk("rst5_pl_ready", 64'(bus.pl_ready), 64'd0);
    exp_q.delete();
    exp_tlv = 0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst5_no_partial", 64'(bus.ob_empty), 64'd1);

    // Reads on an empty FIFO, then random back-to-back traffic.
    rd_mode = 2;
    repeat (6) @(negedge clk);
    chk("rd_empty_empty", 64'(bus.ob_empty), 64'd1);
    chk("rd_empty_tdata", bus.ob_tdata, 64'd0);
    rd_mode = 1;
    gap_max = 2;
    for (int k = 0; k < 14; k++) begin
      send_tlv(8'($urandom), 16'($urandom_range(0, 10)), 40'({$urandom, $urandom}), 8'($urandom));
    end
    drain("t6");
    chk("t6_tlv_cnt_val", 64'(bus.tlv_cnt), 64'd14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
